// File: rtl/mem_pkg.sv
// Shared types and width defaults for the memory pipeline stage.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 64;
    localparam int unsigned MEM_DATA_W = 64;
    localparam int unsigned MEM_REG_W  = 4;
    localparam int unsigned RFLAGS_W   = 64;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic [MEM_REG_W-1:0]  reg_idx;
        logic                  en;
        logic [MEM_DATA_W-1:0] data;
        logic [RFLAGS_W-1:0]   rflags;
    } wb_pkt_t;

endpackage

// File: rtl/mem_req_if.sv
// Valid/ready memory request register: fields are captured on start and held
// unchanged until the handshake, after which valid drops.
module mem_req_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              mreq_ready,
    output logic              mreq_valid,
    output logic              mreq_we,
    output logic [ADDR_W-1:0] mreq_addr,
    output logic [DATA_W-1:0] mreq_wdata,
    output logic              handshake
);

    logic              valid_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign handshake = valid_q & mreq_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            valid_q <= 1'b1;
            we_q    <= start_we;
            addr_q  <= start_addr;
            wdata_q <= start_wdata;
        end else if (handshake) begin
            valid_q <= 1'b0;
        end
    end

    assign mreq_valid = valid_q;
    assign mreq_we    = we_q;
    assign mreq_addr  = addr_q;
    assign mreq_wdata = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: one data access per instruction, writeback packet out.
// Optional MEM_STAGE_PERF_EN adds load/store/stall performance counters.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned REG_W  = MEM_REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exe_mem,
    input  logic [127:0]      ex_result,
    input  logic [63:0]       ex_rflags,
    input  logic [63:0]       ex_store_data,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [REG_W-1:0]  ex_dst_reg,
    input  logic              ex_dst_en,
    output logic              mem_blocked,
    output logic              mreq_valid,
    input  logic              mreq_ready,
    output logic              mreq_we,
    output logic [ADDR_W-1:0] mreq_addr,
    output logic [DATA_W-1:0] mreq_wdata,
    input  logic              mresp_valid,
    input  logic [DATA_W-1:0] mresp_data,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_reg,
    output logic              wb_en,
    output logic [DATA_W-1:0] wb_data,
`ifdef MEM_STAGE_PERF_EN
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic [63:0]       wb_rflags
);

    mem_state_t state_q, state_d;

    logic             is_mem_op;
    logic             accept;
    logic             start;
    logic             handshake;
    logic             mem_done;
    logic             wb_fire;
    logic             wb_valid_q;
    logic             mem_blocked_q;
    wb_pkt_t          wb_q, wb_d;

    logic             is_load_q;
    logic [REG_W-1:0] dst_q;
    logic             dst_en_q;
    logic [63:0]      rflags_q;

    // IMUL high half never reaches the register file.
    logic unused_ex_hi;
    assign unused_ex_hi = ^ex_result[127:64];

    assign is_mem_op = ex_mem_rd | ex_mem_wr;
    assign accept    = (state_q == IDLE) & exe_mem;
    assign start     = accept & is_mem_op;

    mem_req_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_we    (ex_mem_wr),
        .start_addr  (ADDR_W'(ex_result[63:0])),
        .start_wdata (DATA_W'(ex_store_data)),
        .mreq_ready  (mreq_ready),
        .mreq_valid  (mreq_valid),
        .mreq_we     (mreq_we),
        .mreq_addr   (mreq_addr),
        .mreq_wdata  (mreq_wdata),
        .handshake   (handshake)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (handshake) state_d = mresp_valid ? IDLE : WAIT;
            WAIT:    if (mresp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A response coinciding with the request handshake completes the access at once.
    always_comb begin
        wb_fire  = 1'b0;
        wb_d     = wb_q;
        mem_done = ((state_q == REQ) & handshake & mresp_valid) |
                   ((state_q == WAIT) & mresp_valid);
        if (accept && !is_mem_op) begin
            wb_fire        = 1'b1;
            wb_d.reg_idx   = ex_dst_reg;
            wb_d.en        = ex_dst_en;
            wb_d.data      = ex_result[63:0];
            wb_d.rflags    = ex_rflags;
        end else if (mem_done) begin
            wb_fire        = 1'b1;
            wb_d.reg_idx   = dst_q;
            wb_d.en        = is_load_q & dst_en_q;
            wb_d.data      = is_load_q ? mresp_data : DATA_W'(mreq_addr);
            wb_d.rflags    = rflags_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_load_q <= 1'b0;
            dst_q     <= '0;
            dst_en_q  <= 1'b0;
            rflags_q  <= '0;
        end else if (start) begin
            is_load_q <= ex_mem_rd & ~ex_mem_wr;
            dst_q     <= ex_dst_reg;
            dst_en_q  <= ex_dst_en;
            rflags_q  <= ex_rflags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q    <= 1'b0;
            wb_q          <= '0;
            mem_blocked_q <= 1'b0;
        end else begin
            wb_valid_q    <= wb_fire;
            wb_q          <= wb_d;
            mem_blocked_q <= (state_d != IDLE);
        end
    end

    assign mem_blocked = mem_blocked_q;
    assign wb_valid    = wb_valid_q;
    assign wb_reg      = wb_q.reg_idx;
    assign wb_en       = wb_q.en;
    assign wb_data     = wb_q.data;
    assign wb_rflags   = wb_q.rflags;

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_loads_q, perf_stores_q, perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (mem_done && is_load_q)  perf_loads_q  <= perf_loads_q + 32'd1;
            if (mem_done && !is_load_q) perf_stores_q <= perf_stores_q + 32'd1;
            if (mem_blocked_q)          perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_loads        = perf_loads_q;
    assign perf_stores       = perf_stores_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; writeback packets checked against a scoreboard queue.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         exe_mem;
    logic [127:0] ex_result;
    logic [63:0]  ex_rflags;
    logic [63:0]  ex_store_data;
    logic         ex_mem_rd;
    logic         ex_mem_wr;
    logic [3:0]   ex_dst_reg;
    logic         ex_dst_en;
    logic         mem_blocked;
    logic         mreq_valid;
    logic         mreq_ready;
    logic         mreq_we;
    logic [63:0]  mreq_addr;
    logic [63:0]  mreq_wdata;
    logic         mresp_valid;
    logic [63:0]  mresp_data;
    logic         wb_valid;
    logic [3:0]   wb_reg;
    logic         wb_en;
    logic [63:0]  wb_data;
    logic [63:0]  wb_rflags;
`ifdef MEM_STAGE_PERF_EN
    logic [31:0]  perf_loads;
    logic [31:0]  perf_stores;
    logic [31:0]  perf_stall_cycles;
`endif

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .exe_mem       (exe_mem),
        .ex_result     (ex_result),
        .ex_rflags     (ex_rflags),
        .ex_store_data (ex_store_data),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_dst_reg    (ex_dst_reg),
        .ex_dst_en     (ex_dst_en),
        .mem_blocked   (mem_blocked),
        .mreq_valid    (mreq_valid),
        .mreq_ready    (mreq_ready),
        .mreq_we       (mreq_we),
        .mreq_addr     (mreq_addr),
        .mreq_wdata    (mreq_wdata),
        .mresp_valid   (mresp_valid),
        .mresp_data    (mresp_data),
        .wb_valid      (wb_valid),
        .wb_reg        (wb_reg),
        .wb_en         (wb_en),
        .wb_data       (wb_data),
`ifdef MEM_STAGE_PERF_EN
        .perf_loads        (perf_loads),
        .perf_stores       (perf_stores),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .wb_rflags     (wb_rflags)
    );

    typedef struct {
        logic [3:0]  r;
        logic        en;
        logic [63:0] data;
        logic [63:0] flags;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   blk_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [63:0] lo,
                         input logic [63:0] sdata, input logic [3:0] dst, input logic en,
                         input logic [63:0] flags);
        exe_mem       = 1'b1;
        ex_mem_rd     = rd;
        ex_mem_wr     = wr;
        ex_result     = {64'hCAFE_0000_0000_0001, lo};
        ex_store_data = sdata;
        ex_dst_reg    = dst;
        ex_dst_en     = en;
        ex_rflags     = flags;
    endtask

    task automatic push(input logic [3:0] r, input logic en, input logic [63:0] d,
                        input logic [63:0] f);
        exp_t e;
        e.r     = r;
        e.en    = en;
        e.data  = d;
        e.flags = f;
        sb_q.push_back(e);
    endtask

    task automatic check_reset(input string p);
        check({p, "_mem_blocked"}, mem_blocked, 0);
        check({p, "_mreq_valid"},  mreq_valid,  0);
        check({p, "_mreq_we"},     mreq_we,     0);
        check({p, "_mreq_addr"},   mreq_addr,   0);
        check({p, "_mreq_wdata"},  mreq_wdata,  0);
        check({p, "_wb_valid"},    wb_valid,    0);
        check({p, "_wb_en"},       wb_en,       0);
        check({p, "_wb_reg"},      wb_reg,      0);
        check({p, "_wb_data"},     wb_data,     0);
        check({p, "_wb_rflags"},   wb_rflags,   0);
    endtask

    // Scoreboard consumer: every writeback pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (mem_blocked) blk_cnt++;
        if (wb_valid) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", wb_valid, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_reg",    wb_reg,    mon_e.r);
                check("wb_en",     wb_en,     mon_e.en);
                check("wb_data",   wb_data,   mon_e.data);
                check("wb_rflags", wb_rflags, mon_e.flags);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        exe_mem       = 1'b0;
        ex_result     = '0;
        ex_rflags     = '0;
        ex_store_data = '0;
        ex_mem_rd     = 1'b0;
        ex_mem_wr     = 1'b0;
        ex_dst_reg    = '0;
        ex_dst_en     = 1'b0;
        mreq_ready    = 1'b0;
        mresp_valid   = 1'b0;
        mresp_data    = '0;

        tick();
        tick();
        @(negedge clk);
        check_reset("rst");
        tick();
        reset = 1'b0;

        // Non-memory op, latency 1
        drive(1'b0, 1'b0, 64'h1234, 64'h0, 4'd3, 1'b1, 64'hA5);
        push(4'd3, 1'b1, 64'h1234, 64'hA5);
        tick();
        exe_mem = 1'b0;
        @(negedge clk);
        check("alu_wb_valid", wb_valid, 1);
        check("alu_blocked", mem_blocked, 0);
        tick();
        @(negedge clk);
        check("alu_wb_pulse", wb_valid, 0);

        // Load with ready low for three cycles; stray exe_mem/mresp while blocked
        drive(1'b1, 1'b0, 64'h1000, 64'h0, 4'd5, 1'b1, 64'h11);
        push(4'd5, 1'b1, 64'hDEAD, 64'h11);
        mreq_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                drive(1'b0, 1'b0, 64'h7777, 64'h0, 4'd1, 1'b1, 64'h0);
                mresp_valid = 1'b1;
                mresp_data  = 64'hBAD;
            end
            if (k == 1) begin
                exe_mem     = 1'b0;
                mresp_valid = 1'b0;
            end
            if (k == 3) mreq_ready = 1'b1;
            @(negedge clk);
            check("ld_req_valid", mreq_valid, 1);
            check("ld_req_addr", mreq_addr, 64'h1000);
            check("ld_req_we", mreq_we, 0);
            check("ld_blocked", mem_blocked, 1);
        end
        tick();
        mreq_ready = 1'b0;
        @(negedge clk);
        check("ld_wait_valid", mreq_valid, 0);
        check("ld_wait_blocked", mem_blocked, 1);
        check("ld_wait_addr", mreq_addr, 64'h1000);
        tick();
        mresp_valid = 1'b1;
        mresp_data  = 64'hDEAD;
        @(negedge clk);
        check("ld_wait2_blocked", mem_blocked, 1);
        tick();
        mresp_valid = 1'b0;
        @(negedge clk);
        check("ld_done_wb_valid", wb_valid, 1);
        check("ld_done_blocked", mem_blocked, 0);

        // Store, ack one cycle after handshake
        drive(1'b0, 1'b1, 64'h2000, 64'h55, 4'd7, 1'b1, 64'h22);
        push(4'd7, 1'b0, 64'h2000, 64'h22);
        mreq_ready = 1'b1;
        tick();
        exe_mem = 1'b0;
        @(negedge clk);
        check("st_req_valid", mreq_valid, 1);
        check("st_req_we", mreq_we, 1);
        check("st_req_addr", mreq_addr, 64'h2000);
        check("st_req_wdata", mreq_wdata, 64'h55);
        tick();
        mreq_ready  = 1'b0;
        mresp_valid = 1'b1;
        @(negedge clk);
        check("st_wait_valid", mreq_valid, 0);
        check("st_wait_blocked", mem_blocked, 1);
        tick();
        mresp_valid = 1'b0;
        @(negedge clk);
        check("st_done_wb_valid", wb_valid, 1);
        check("st_done_wb_en", wb_en, 0);
        check("st_done_blocked", mem_blocked, 0);
`ifdef MEM_STAGE_PERF_EN
        check("perf_loads", perf_loads, 1);
        check("perf_stores", perf_stores, 1);
        check("perf_stall", perf_stall_cycles, blk_cnt);
`endif

        // Handshake and response in the same cycle
        drive(1'b1, 1'b0, 64'h3000, 64'h0, 4'd2, 1'b1, 64'h33);
        push(4'd2, 1'b1, 64'hBEEF, 64'h33);
        mreq_ready  = 1'b1;
        mresp_valid = 1'b1;
        mresp_data  = 64'hBEEF;
        tick();
        exe_mem = 1'b0;
        @(negedge clk);
        check("sc_req_valid", mreq_valid, 1);
        check("sc_blocked", mem_blocked, 1);
        tick();
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        @(negedge clk);
        check("sc_wb_valid", wb_valid, 1);
        check("sc_blocked_done", mem_blocked, 0);
        check("sc_req_dropped", mreq_valid, 0);
        tick();
        @(negedge clk);
        check("sc_single_pulse", wb_valid, 0);

        // Read and write both set: behaves as a store
        drive(1'b1, 1'b1, 64'h4000, 64'h66, 4'd9, 1'b1, 64'h44);
        push(4'd9, 1'b0, 64'h4000, 64'h44);
        mreq_ready = 1'b1;
        tick();
        exe_mem = 1'b0;
        @(negedge clk);
        check("ill_req_we", mreq_we, 1);
        tick();
        mreq_ready  = 1'b0;
        mresp_valid = 1'b1;
        tick();
        mresp_valid = 1'b0;
        @(negedge clk);
        check("ill_wb_en", wb_en, 0);

        // Four back-to-back non-memory ops
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 64'h100 + 64'(i), 64'h0, 4'(i), i[0], 64'(i));
            push(4'(i), i[0], 64'h100 + 64'(i), 64'(i));
            tick();
            @(negedge clk);
            check("b2b_wb_valid", wb_valid, 1);
        end
        exe_mem = 1'b0;
        tick();
        @(negedge clk);
        check("b2b_idle", wb_valid, 0);

        // Reset while waiting for a response, then a stray late response
        drive(1'b1, 1'b0, 64'h5000, 64'h0, 4'd6, 1'b1, 64'h55);
        mreq_ready = 1'b1;
        tick();
        exe_mem = 1'b0;
        tick();
        mreq_ready = 1'b0;
        @(negedge clk);
        check("rw_wait_blocked", mem_blocked, 1);
        check("rw_wait_valid", mreq_valid, 0);
        reset = 1'b1;
        #2;
        check_reset("rw_async");
        tick();
        reset       = 1'b0;
        mresp_valid = 1'b1;
        mresp_data  = 64'hBAD;
        tick();
        mresp_valid = 1'b0;
        @(negedge clk);
        check_reset("rw_stray");
        tick();
        @(negedge clk);
        check("rw_no_wb", wb_valid, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute ALU.
- Consumes the registered ALU result, rflags and exe_mem valid. Performs at most one data-memory access per instruction through a valid/ready request and response port. Delivers a writeback packet to the register file.
- Drives mem_blocked back to the ALU so that stage holds its outputs while a memory access is outstanding.

Parameters:
- ADDR_W, 64, width of the memory address.
- DATA_W, 64, width of memory and writeback data.
- REG_W, 4, width of the GPR index.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- exe_mem  in  1  ALU output valid.
- ex_result  in  128  ALU result. Bits [63:0] are the address for loads/stores, or the data for non-memory ops.
- ex_rflags  in  64  ALU flags, passed through.
- ex_store_data  in  64  store data.
- ex_mem_rd  in  1  instruction loads.
- ex_mem_wr  in  1  instruction stores.
- ex_dst_reg  in  REG_W  destination GPR.
- ex_dst_en  in  1  instruction writes a GPR.
- mem_blocked  out  1  stall to the ALU.
- mreq_valid  out  1  memory request valid.
- mreq_ready  in  1  memory accepts request.
- mreq_we  out  1  1 = store.
- mreq_addr  out  ADDR_W  request address.
- mreq_wdata  out  DATA_W  store data.
- mresp_valid  in  1  response valid; for a store this is the write acknowledge.
- mresp_data  in  DATA_W  load data.
- wb_valid  out  1  writeback packet valid (one-cycle pulse per instruction).
- wb_reg  out  REG_W  destination GPR.
- wb_en  out  1  GPR write enable.
- wb_data  out  DATA_W  writeback value.
- wb_rflags  out  64  flags to commit.

Behaviour:
- Reset values: state=IDLE; mem_blocked=0; mreq_valid=0; mreq_we=0; mreq_addr=0; mreq_wdata=0; wb_valid=0; wb_en=0; wb_reg=0; wb_data=0; wb_rflags=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, exe_mem=1, no memory op:
  - Next cycle: wb_valid=1, wb_data=ex_result[63:0], wb_en=ex_dst_en, wb_reg/wb_rflags latched. Latency 1.
- IDLE, exe_mem=1 with ex_mem_rd or ex_mem_wr:
  - Latch the packet, including address = ex_result[63:0].
  - Go to REG; mreq_valid=1 and mem_blocked=1 from the next cycle.
- REQ:
  - Hold mreq_* stable until mreq_ready=1.
  - On handshake: mreq_valid drops the next cycle and state goes to WAIT.
  - If mresp_valid arrives in the same cycle as the handshake, treat it as WAIT completion and return straight to IDLE.
- WAIT, on mresp_valid:
  - Load: wb_data=mresp_data, wb_en=ex_dst_en.
  - Store: wb_en=0, wb_data=address.
  - wb_valid=1 for one cycle; mem_blocked deasserts the same cycle; state=IDLE.
- mem_blocked is registered. It is 1 in every cycle the state is REQ or WAIT, so the ALU sees it on the cycle its next exe_mem would be consumed.
- exe_mem while blocked: ignored. The ALU holds, so there is no data loss.
- ex_mem_rd and ex_mem_wr both set: illegal. Treat as store; wb_en=0.
- mresp_valid in IDLE or REQ-without-handshake: ignored.
- Back-to-back non-memory ops: one wb_valid per cycle, no bubbles.
- wb_valid=0 in every cycle without a completing instruction; other wb_* hold their last value.
- Reset mid-access: all state clears immediately and mreq_valid drops. A late mresp_valid after reset is ignored because state is IDLE.
- Widths: the upper 64 bits of ex_result are dropped in writeback; IMUL high half is not written.

Optional Feature:
- Macro: MEM_STAGE_PERF_EN.
- Defined: adds outputs perf_loads[31:0], perf_stores[31:0] and perf_stall_cycles[31:0].
  - Loads and stores increment on wb_valid for the matching type.
  - perf_stall_cycles increments every cycle mem_blocked=1.
  - All counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg:
  - typedef enum mem_state_t {IDLE, REQ, WAIT}.
  - struct wb_pkt_t {reg, en, data, rflags}.
  - ADDR_W/DATA_W defaults.
- One sub-module is natural: mem_req_if. It holds the valid/ready request register, with mreq_* stable until handshake.
- FSM and writeback mux remain in mem_stage.

Test Plan:
- Non-memory op: exe_mem=1, ex_result=0x1234, ex_dst_reg=3, ex_dst_en=1 -> next cycle wb_valid=1, wb_reg=3, wb_data=0x1234, mem_blocked=0.
- Load with mreq_ready=0 for 3 cycles:
  - Stimulus: address 0x1000; mreq_ready low 3 cycles, then high; mresp_data=0xdead after 2 more cycles.
  - Response: mreq_addr=0x1000 held stable throughout; mem_blocked=1 until the response cycle; wb_data=0xdead, wb_en=1.
- Store: ex_mem_wr=1, address 0x2000, store_data=0x55, mreq_ready=1, ack after 1 cycle -> mreq_we=1, mreq_wdata=0x55, wb_valid=1 with wb_en=0.
- Same-cycle handshake+response: mreq_ready=1 and mresp_valid=1 together -> FSM goes REQ to IDLE, exactly one wb_valid.
- Reset in WAIT: assert reset, then a stray mresp_valid -> all outputs at reset values, no wb_valid.
- Back-to-back: 4 consecutive non-memory ops -> 4 consecutive wb_valid pulses. With MEM_STAGE_PERF_EN defined, after the load/store tests perf_loads=1, perf_stores=1, and perf_stall_cycles equals the observed mem_blocked cycle count.
